product_accumulator: RTL and testbench

PRODUCT_ACCUMULATOR -- requirements
Module: product_accumulator

---
 rtl/product_accumulator_pkg.sv | 33 +++
 rtl/product_accumulator_acc_add.sv | 29 ++
 rtl/product_accumulator.sv | 102 ++++++++++
 tb/tb_product_accumulator.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/product_accumulator_pkg.sv
// product_accumulator_pkg: shared parameter defaults, FSM state encoding and clog2.
// Rev 1.0
`default_nettype none

package product_accumulator_pkg;

  localparam int DEF_N     = 8;
  localparam int DEF_LEN   = 4;
  localparam int DEF_ACC_W = 2 * DEF_N + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v      = value - 1;
    for (int i = 0; i < 32; i++) begin
      if (v > 0) begin
        result = result + 1;
        v      = v >> 1;
      end
    end
    return result;
  endfunction

endpackage

`default_nettype wire

// File: rtl/product_accumulator_acc_add.sv
// acc_add: combinational ACC_W adder with carry out; clamps to all-ones on carry
// when ACC_SATURATE_EN is defined. Rev 1.0
`default_nettype none

module acc_add
  import product_accumulator_pkg::*;
#(
  parameter int ACC_W = DEF_ACC_W
) (
  input  logic [ACC_W-1:0] a,
  input  logic [ACC_W-1:0] b,
  output logic [ACC_W-1:0] sum,
  output logic             carry
);

  logic [ACC_W:0] full;

  assign full  = {1'b0, a} + {1'b0, b};
  assign carry = full[ACC_W];

`ifdef ACC_SATURATE_EN
  assign sum = carry ? {ACC_W{1'b1}} : full[ACC_W-1:0];
`else
  assign sum = full[ACC_W-1:0];
`endif

endmodule

`default_nettype wire

// File: rtl/product_accumulator.sv
// product_accumulator: sums LEN unsigned products per result with valid/ready
// handshakes and a sticky overflow flag; ACC_SATURATE_EN selects clamping. Rev 1.0
`default_nettype none

module product_accumulator
  import product_accumulator_pkg::*;
#(
  parameter int N     = DEF_N,
  parameter int LEN   = DEF_LEN,
  parameter int ACC_W = 2 * N + 1
) (
  input  logic             clk,
  input  logic             stop_n,
  input  logic             clear,
  input  logic             prod_valid,
  input  logic [2*N-1:0]   prod,
  output logic             prod_ready,
  output logic [ACC_W-1:0] sum,
  output logic             sum_valid,
  input  logic             sum_ready,
  output logic             ovf
);

  localparam int CNT_W = clog2(LEN + 1);

  state_t            state;
  state_t            next_state;
  logic [ACC_W-1:0]  acc;
  logic [CNT_W-1:0]  cnt;
  logic [ACC_W-1:0]  prod_ext;
  logic [ACC_W-1:0]  add_sum;
  logic              add_carry;
  logic              beat;
  logic              last_beat;

  assign prod_ext  = ACC_W'(prod);
  assign beat      = prod_valid & prod_ready;
  assign last_beat = (cnt == CNT_W'(LEN - 1));
  assign sum       = acc;

  acc_add #(
    .ACC_W (ACC_W)
  ) u_acc_add (
    .a     (acc),
    .b     (prod_ext),
    .sum   (add_sum),
    .carry (add_carry)
  );

  always_ff @(posedge clk or negedge stop_n) begin
    if (!stop_n) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // clear outranks both the product beat and the result handshake
  always_comb begin
    next_state = state;
    if (clear) begin
      next_state = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:  if (beat) next_state = (LEN == 1) ? ST_DONE : ST_ACCUM;
        ST_ACCUM: if (beat && last_beat) next_state = ST_DONE;
        ST_DONE:  if (sum_ready) next_state = ST_IDLE;
        default:  next_state = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    prod_ready = (state != ST_DONE);
    sum_valid  = (state == ST_DONE);
  end

  always_ff @(posedge clk or negedge stop_n) begin
    if (!stop_n) begin
      acc <= '0;
      cnt <= '0;
      ovf <= 1'b0;
    end else if (clear) begin
      acc <= '0;
      cnt <= '0;
      ovf <= 1'b0;
    end else if (beat) begin
      if (state == ST_IDLE) begin
        acc <= prod_ext;
        cnt <= CNT_W'(1);
        ovf <= 1'b0;
      end else begin
        acc <= add_sum;
        cnt <= cnt + CNT_W'(1);
        ovf <= ovf | add_carry;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_product_accumulator.sv
// tb_product_accumulator: randomized and directed checks against an arithmetic
// reference model of the product accumulator.
`default_nettype none

module tb_product_accumulator;

  localparam int N     = 8;
  localparam int LEN   = 4;
  localparam int ACC_W = 17;

  logic             clk;
  logic             stop_n;
  logic             clear;
  logic             prod_valid;
  logic [2*N-1:0]   prod;
  logic             prod_ready;
  logic [ACC_W-1:0] sum;
  logic             sum_valid;
  logic             sum_ready;
  logic             ovf;

  int checks;
  int errors;
  int unsigned beats [LEN];

  product_accumulator #(
    .N     (N),
    .LEN   (LEN),
    .ACC_W (ACC_W)
  ) dut (
    .clk        (clk),
    .stop_n     (stop_n),
    .clear      (clear),
    .prod_valid (prod_valid),
    .prod       (prod),
    .prod_ready (prod_ready),
    .sum        (sum),
    .sum_valid  (sum_valid),
    .sum_ready  (sum_ready),
    .ovf        (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain sum of the beats, then wrap or clamp at 2^ACC_W
  task automatic model(output logic [63:0] exp_sum, output logic exp_ovf);
    longint total;
    longint limit;
    total = 0;
    limit = longint'(1) << ACC_W;
    for (int i = 0; i < LEN; i++) total += longint'(beats[i]);
    exp_ovf = (total >= limit);
`ifdef ACC_SATURATE_EN
    exp_sum = exp_ovf ? 64'(limit - 1) : 64'(total);
`else
    exp_sum = 64'(total % limit);
`endif
  endtask

  task automatic beat(input int unsigned v);
    prod_valid = 1'b1;
    prod       = v[2*N-1:0];
    tick();
    prod_valid = 1'b0;
  endtask

  task automatic do_result(input string tag, input int gap_lo, input int gap_hi, input int hold);
    logic [63:0] exp_sum;
    logic        exp_ovf;
    int          gaps;
    model(exp_sum, exp_ovf);
    for (int i = 0; i < LEN; i++) begin
      gaps = $urandom_range(gap_hi, gap_lo);
      for (int g = 0; g < gaps; g++) begin
        prod_valid = 1'b0;
        prod       = 16'($urandom);
        tick();
        check({tag, "_gap_sv"}, 64'(sum_valid), 64'd0);
      end
      check({tag, "_ready"}, 64'(prod_ready), 64'd1);
      beat(beats[i]);
      if (i < LEN - 1) check({tag, "_early_sv"}, 64'(sum_valid), 64'd0);
    end
    check({tag, "_sv"}, 64'(sum_valid), 64'd1);
    check({tag, "_sum"}, 64'(sum), exp_sum);
    check({tag, "_ovf"}, 64'(ovf), 64'(exp_ovf));
    for (int h = 0; h < hold; h++) begin
      prod_valid = 1'b1;
      prod       = 16'($urandom);
      tick();
      check({tag, "_hold_sum"}, 64'(sum), exp_sum);
      check({tag, "_hold_ovf"}, 64'(ovf), 64'(exp_ovf));
      check({tag, "_hold_pr"}, 64'(prod_ready), 64'd0);
      check({tag, "_hold_sv"}, 64'(sum_valid), 64'd1);
    end
    prod_valid = 1'b0;
    sum_ready  = 1'b1;
    tick();
    sum_ready = 1'b0;
    check({tag, "_release_sv"}, 64'(sum_valid), 64'd0);
    check({tag, "_release_pr"}, 64'(prod_ready), 64'd1);
  endtask

  initial begin
    logic [63:0] exp_sum;
    logic        exp_ovf;
    checks     = 0;
    errors     = 0;
    stop_n     = 1'b0;
    clear      = 1'b0;
    prod_valid = 1'b0;
    prod       = '0;
    sum_ready  = 1'b0;

    #2;
    check("rst_sum", 64'(sum), 64'd0);
    check("rst_sv", 64'(sum_valid), 64'd0);
    check("rst_ovf", 64'(ovf), 64'd0);
    check("rst_pr", 64'(prod_ready), 64'd1);
    tick();
    stop_n = 1'b1;
    tick();

    beats = '{3, 5, 7, 9};
    do_result("basic", 0, 0, 0);

    beats = '{65025, 65025, 65025, 0};
    do_result("ovf", 0, 0, 1);

    beats = '{3, 5, 7, 9};
    do_result("hold5", 0, 0, 5);

    // sum_ready and a product together in DONE: product waits for IDLE
    beat(3); beat(5); beat(7); beat(9);
    check("done_sv", 64'(sum_valid), 64'd1);
    sum_ready  = 1'b1;
    prod_valid = 1'b1;
    prod       = 16'd11;
    tick();
    sum_ready = 1'b0;
    check("rel_sv", 64'(sum_valid), 64'd0);
    check("rel_pr", 64'(prod_ready), 64'd1);
    beat(11); beat(12); beat(13);
    check("rel_early_sv", 64'(sum_valid), 64'd0);
    beat(14);
    check("rel_sv2", 64'(sum_valid), 64'd1);
    check("rel_sum", 64'(sum), 64'd50);
    sum_ready = 1'b1;
    tick();
    sum_ready = 1'b0;

    // clear after two beats discards them and any product that cycle
    beat(50); beat(60);
    clear      = 1'b1;
    prod_valid = 1'b1;
    prod       = 16'd100;
    tick();
    clear      = 1'b0;
    prod_valid = 1'b0;
    check("clr_sv", 64'(sum_valid), 64'd0);
    check("clr_ovf", 64'(ovf), 64'd0);
    check("clr_pr", 64'(prod_ready), 64'd1);
    beats = '{1, 1, 1, 1};
    do_result("clr", 0, 0, 0);

    // clear while holding a result drops it
    beats = '{65025, 65025, 65025, 0};
    for (int i = 0; i < LEN; i++) beat(beats[i]);
    clear     = 1'b1;
    sum_ready = 1'b0;
    tick();
    clear = 1'b0;
    check("clr_done_sv", 64'(sum_valid), 64'd0);
    check("clr_done_ovf", 64'(ovf), 64'd0);
    check("clr_done_pr", 64'(prod_ready), 64'd1);

    // asynchronous reset mid-accumulation
    beat(70); beat(80);
    stop_n = 1'b0;
    #1;
    check("amid_sum", 64'(sum), 64'd0);
    check("amid_sv", 64'(sum_valid), 64'd0);
    check("amid_ovf", 64'(ovf), 64'd0);
    check("amid_pr", 64'(prod_ready), 64'd1);
    #2;
    stop_n = 1'b1;
    beats = '{2, 2, 2, 2};
    do_result("after_rst", 0, 0, 0);

    beats = '{10, 20, 30, 40};
    do_result("toggle", 1, 1, 0);

    for (int r = 0; r < 25; r++) begin
      for (int i = 0; i < LEN; i++) begin
        beats[i] = ($urandom_range(3, 0) == 0) ? $urandom_range(65535, 60000)
                                                : $urandom_range(65535, 0);
      end
      do_result("rand", 0, 2, int'($urandom_range(3, 0)));
    end

    model(exp_sum, exp_ovf);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
